// File: rtl/dsp_adder_pkg.sv
// Shared constants and helpers for the DSP-limb wide adder.
package dsp_adder_pkg;

    localparam int LIMB_BITS_DEFAULT = 47;
    localparam int DSP_WIDTH         = 48;

    typedef logic [DSP_WIDTH-1:0] dsp_word_t;

    function automatic int num_limbs(input int width, input int limb_bits);
        return (width + limb_bits - 1) / limb_bits;
    endfunction

endpackage

// File: rtl/dsp_limb_adder.sv
// One registered limb: sum = a + b + cin, carry in the top bit.
// DSP_WIDE_ADDER_PRIMITIVE_EN selects a DSP48E2 instead of a behavioural add.
module dsp_limb_adder
    import dsp_adder_pkg::*;
#(
    parameter int LIMB_BITS = LIMB_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic [LIMB_BITS-1:0] a,
    input  logic [LIMB_BITS-1:0] b,
    input  logic                 cin,
    output logic [LIMB_BITS:0]   sum
);

`ifdef DSP_WIDE_ADDER_PRIMITIVE_EN

    dsp_word_t ab_w;
    dsp_word_t c_w;
    dsp_word_t p_w;

    assign ab_w = {{(DSP_WIDTH - LIMB_BITS){1'b0}}, a};
    assign c_w  = {{(DSP_WIDTH - LIMB_BITS){1'b0}}, b};

    // P = W(C) + X(A:B) + CARRYIN with only the P register enabled.
    DSP48E2 #(
        .USE_MULT         ("NONE"),
        .AREG             (0),
        .BREG             (0),
        .CREG             (0),
        .DREG             (0),
        .ADREG            (0),
        .MREG             (0),
        .PREG             (1),
        .ACASCREG         (0),
        .BCASCREG         (0),
        .ALUMODEREG       (0),
        .CARRYINREG       (0),
        .CARRYINSELREG    (0),
        .INMODEREG        (0),
        .OPMODEREG        (0)
    ) u_dsp (
        .CLK              (clk),
        .A                (ab_w[47:18]),
        .B                (ab_w[17:0]),
        .C                (c_w),
        .D                (27'd0),
        .ALUMODE          (4'b0000),
        .OPMODE           (9'b11_000_00_11),
        .INMODE           (5'b00000),
        .CARRYIN          (cin),
        .CARRYINSEL       (3'b000),
        .ACIN             (30'd0),
        .BCIN             (18'd0),
        .PCIN             (48'd0),
        .CARRYCASCIN      (1'b0),
        .MULTSIGNIN       (1'b0),
        .CEA1             (1'b1),
        .CEA2             (1'b1),
        .CEAD             (1'b1),
        .CEALUMODE        (1'b1),
        .CEB1             (1'b1),
        .CEB2             (1'b1),
        .CEC              (1'b1),
        .CECARRYIN        (1'b1),
        .CECTRL           (1'b1),
        .CED              (1'b1),
        .CEINMODE         (1'b1),
        .CEM              (1'b1),
        .CEP              (1'b1),
        .RSTA             (1'b0),
        .RSTALLCARRYIN    (1'b0),
        .RSTALUMODE       (1'b0),
        .RSTB             (1'b0),
        .RSTC             (1'b0),
        .RSTCTRL          (1'b0),
        .RSTD             (1'b0),
        .RSTINMODE        (1'b0),
        .RSTM             (1'b0),
        .RSTP             (1'b0),
        .P                (p_w),
        .ACOUT            (),
        .BCOUT            (),
        .PCOUT            (),
        .CARRYOUT         (),
        .CARRYCASCOUT     (),
        .MULTSIGNOUT      (),
        .OVERFLOW         (),
        .UNDERFLOW        (),
        .PATTERNDETECT    (),
        .PATTERNBDETECT   (),
        .XOROUT           ()
    );

    assign sum = p_w[LIMB_BITS:0];

`else

    logic [LIMB_BITS:0] sum_d;
    logic [LIMB_BITS:0] sum_q;

    always_comb begin
        sum_d = {1'b0, a} + {1'b0, b} + {{LIMB_BITS{1'b0}}, cin};
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    assign sum = sum_q;

`endif

endmodule

// File: rtl/dsp_wide_adder.sv
// Pipelined WIDTH-bit add/sub from a skewed chain of registered limbs.
// Build with DSP_WIDE_ADDER_PRIMITIVE_EN to map each limb onto a DSP48E2.
module dsp_wide_adder
    import dsp_adder_pkg::*;
#(
    parameter int WIDTH     = 1024,
    parameter int LIMB_BITS = LIMB_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int NUM_LIMBS = num_limbs(WIDTH, LIMB_BITS);
    localparam int TOP_BITS  = WIDTH - (NUM_LIMBS - 1) * LIMB_BITS;

    // carry[k] feeds limb k; carry[NUM_LIMBS] is the final carry/no-borrow.
    logic [NUM_LIMBS:0] carry;
    logic [WIDTH-1:0]   sum_aligned;

    assign carry[0] = in_sub;

    for (genvar k = 0; k < NUM_LIMBS; k++) begin : g_limb
        localparam int LW     = (k == NUM_LIMBS - 1) ? TOP_BITS : LIMB_BITS;
        localparam int SKEW   = k;
        localparam int DESKEW = NUM_LIMBS - 1 - k;

        logic [LW-1:0] a_in;
        logic [LW-1:0] b_in;
        logic [LW-1:0] a_stage;
        logic [LW-1:0] b_stage;
        logic [LW:0]   limb_sum;
        logic [LW-1:0] limb_out;

        // Inverting at limb width keeps the top limb's unused bits out of the add.
        assign a_in = in_a[k*LIMB_BITS +: LW];
        assign b_in = in_sub ? ~in_b[k*LIMB_BITS +: LW] : in_b[k*LIMB_BITS +: LW];

        if (SKEW == 0) begin : g_noskew
            assign a_stage = a_in;
            assign b_stage = b_in;
        end else begin : g_skew
            logic [LW-1:0] skew_a_d [SKEW];
            logic [LW-1:0] skew_a_q [SKEW];
            logic [LW-1:0] skew_b_d [SKEW];
            logic [LW-1:0] skew_b_q [SKEW];

            always_comb begin
                skew_a_d[0] = a_in;
                skew_b_d[0] = b_in;
                for (int i = 1; i < SKEW; i++) begin
                    skew_a_d[i] = skew_a_q[i-1];
                    skew_b_d[i] = skew_b_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                skew_a_q <= skew_a_d;
                skew_b_q <= skew_b_d;
            end

            assign a_stage = skew_a_q[SKEW-1];
            assign b_stage = skew_b_q[SKEW-1];
        end

        dsp_limb_adder #(
            .LIMB_BITS (LW)
        ) u_limb (
            .clk (clk),
            .a   (a_stage),
            .b   (b_stage),
            .cin (carry[k]),
            .sum (limb_sum)
        );

        assign carry[k+1] = limb_sum[LW];

        if (DESKEW == 0) begin : g_nodeskew
            assign limb_out = limb_sum[LW-1:0];
        end else begin : g_deskew
            logic [LW-1:0] deskew_d [DESKEW];
            logic [LW-1:0] deskew_q [DESKEW];

            always_comb begin
                deskew_d[0] = limb_sum[LW-1:0];
                for (int i = 1; i < DESKEW; i++) begin
                    deskew_d[i] = deskew_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                deskew_q <= deskew_d;
            end

            assign limb_out = deskew_q[DESKEW-1];
        end

        assign sum_aligned[k*LIMB_BITS +: LW] = limb_out;
    end

    logic [NUM_LIMBS-1:0] valid_d;
    logic [NUM_LIMBS-1:0] valid_q;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data flops are unreset, so outputs are gated to read zero when idle.
    assign out_valid = valid_q[NUM_LIMBS-1];
    assign out_sum   = out_valid ? sum_aligned : '0;
    assign out_carry = out_valid & carry[NUM_LIMBS];

endmodule

// File: tb/tb_dsp_wide_adder.sv
// Self-checking bench for dsp_wide_adder at WIDTH=100, LIMB_BITS=47 (3 limbs).
module tb_dsp_wide_adder;

    localparam int W  = 100;
    localparam int NL = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // expected {carry, sum} and the cycle it must appear in
    logic [W:0] exp_q[$];
    int         exp_cyc_q[$];

    dsp_wide_adder #(
        .WIDTH     (W),
        .LIMB_BITS (47)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
        logic [W-1:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    endfunction

    // scoreboard: every sampled cycle is either a due result or a bubble
    task automatic monitor();
        logic [W:0] e;
        if (exp_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            check_eq("missed_result", 128'(exp_cyc_q[0]), 128'(cyc));
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            e = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            check_eq("out_valid", 128'(out_valid), 128'd1);
            if (out_valid) begin
                check_eq("out_sum", 128'(out_sum), 128'(e[W-1:0]));
                check_eq("out_carry", 128'(out_carry), 128'(e[W]));
            end
        end else begin
            check_eq("bubble", 128'(out_valid), 128'd0);
        end
    endtask

    // driver: sample outputs at the negedge, then present the next input
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W:0] exp);
        @(negedge clk);
        monitor();
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        if (v) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + NL);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        step(1'b1, a, b, sub, ref_op(a, b, sub));
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [127:0] rnd;
    logic [5:0]   bubble_pat;

    initial begin
        ones     = '1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_sub   = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 128'(out_valid), 128'd0);
        check_eq("rst_sum", 128'(out_sum), 128'd0);
        check_eq("rst_carry", 128'(out_carry), 128'd0);
        rst_n = 1'b1;
        idle(2);

        // full carry ripple through every limb
        step(1'b1, ones, 100'd1, 1'b0, {1'b1, {W{1'b0}}});
        idle(4);

        // borrow and equal-operand subtract
        step(1'b1, '0, 100'd1, 1'b1, {1'b0, {W{1'b1}}});
        step(1'b1, 100'h5A5A, 100'h5A5A, 1'b1, {1'b1, {W{1'b0}}});
        // carry across the first limb boundary, and a no-borrow top-bit subtract
        step(1'b1, 100'h7FFF_FFFF_FFFF, 100'd1, 1'b0, {1'b0, 100'h8000_0000_0000});
        step(1'b1, {1'b1, 99'd0}, 100'd1, 1'b1, {1'b1, 1'b0, {99{1'b1}}});
        idle(4);

        // streaming, mixed add/sub back-to-back
        for (int i = 0; i < 6; i++) begin
            op((100'(i) << 47) + 100'(i), (100'd1 << 47) - 100'd1, 1'((i % 3) == 1));
        end
        idle(4);

        // bubble pattern 1,0,1,1,0,1
        bubble_pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            if (bubble_pat[5-i]) op(100'(i * 12345 + 7) << 40, 100'(i + 1) << 60, 1'(i & 1));
            else                 idle(1);
        end
        idle(4);

        // reset pulse while two operations are in flight
        op(100'd11, 100'd22, 1'b0);
        op(100'd33, 100'd44, 1'b1);
        @(negedge clk);
        monitor();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        monitor();
        check_eq("midrst_sum", 128'(out_sum), 128'd0);
        rst_n = 1'b1;
        idle(4);
        op(100'd1000, 100'd1, 1'b1);
        idle(4);

        // random regression with bubbles
        for (int i = 0; i < 10000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            ra  = rnd[W-1:0];
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rb  = rnd[W-1:0];
            if ($urandom_range(0, 15) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) idle(1);
            else                           op(ra, rb, 1'($urandom_range(0, 1)));
        end
        idle(NL + 2);

        check_eq("drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
